fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage (master) and the memory (slave).
interface fetch_stage_if;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic [15:0] IMemRdata;
  logic        IMemValid;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdata,
    input  IMemValid
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdata,
    output IMemValid
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: single-outstanding instruction fetch feeding a 2-entry queue and the decode register.
// Optional redirect counter on RedirectCnt is built only when FETCH_REDIRECT_CNT_EN is defined.
module fetch_stage (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [15:0]   BranchTargetE,
  fetch_stage_if.master imem,
  output logic [15:0]   InstrD,
  output logic [15:0]   PCPlus1D,
  output logic          ValidD
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]   RedirectCnt
`endif
);

  logic [15:0]      pcf_q, pcf_d;
  logic [15:0]      req_pcp1_q, req_pcp1_d;
  logic             outst_q, outst_d;
  logic             drop_q, drop_d;
  logic [1:0][15:0] qi_q, qi_d;
  logic [1:0][15:0] qp_q, qp_d;
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      instrd_q, instrd_d;
  logic [15:0]      pcp1d_q, pcp1d_d;
  logic             validd_q, validd_d;

  logic issue;
  logic resp;
  logic push;
  logic pop;
  logic tail;

  always_comb begin
    // Reset gates the request combinationally so no pulse escapes while held in reset.
    issue = reset & ~StallF & ~PCSrcE & ~outst_q &
            ((count_q + {1'b0, outst_q}) < 2'd2);
    resp  = imem.IMemValid & outst_q;
    push  = resp & ~drop_q & ~PCSrcE;
    pop   = ~FlushD & ~StallD & (count_q != 2'd0);
    tail  = head_q ^ count_q[0];

    pcf_d      = pcf_q;
    req_pcp1_d = req_pcp1_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    qi_d       = qi_q;
    qp_d       = qp_q;
    head_d     = head_q;
    count_d    = count_q;
    instrd_d   = instrd_q;
    pcp1d_d    = pcp1d_q;
    validd_d   = validd_q;

    if (PCSrcE) begin
      pcf_d = BranchTargetE;
    end else if (issue) begin
      pcf_d      = pcf_q + 16'd1;
      req_pcp1_d = pcf_q + 16'd1;
    end

    if (issue) begin
      outst_d = 1'b1;
    end else if (resp) begin
      outst_d = 1'b0;
    end

    if (resp) begin
      drop_d = 1'b0;
    end
    if (PCSrcE && outst_q && !imem.IMemValid) begin
      drop_d = 1'b1;
    end

    if (push) begin
      qi_d[tail] = imem.IMemRdata;
      qp_d[tail] = req_pcp1_q;
    end

    if (PCSrcE) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      head_d  = head_q ^ pop;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    if (FlushD) begin
      instrd_d = 16'h0000;
      pcp1d_d  = 16'h0000;
      validd_d = 1'b0;
    end else if (!StallD) begin
      if (count_q != 2'd0) begin
        instrd_d = qi_q[head_q];
        pcp1d_d  = qp_q[head_q];
        validd_d = 1'b1;
      end else begin
        instrd_d = 16'h0000;
        validd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf_q      <= 16'h0000;
      req_pcp1_q <= 16'h0000;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      qi_q       <= '0;
      qp_q       <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      instrd_q   <= 16'h0000;
      pcp1d_q    <= 16'h0000;
      validd_q   <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      req_pcp1_q <= req_pcp1_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      qi_q       <= qi_d;
      qp_q       <= qp_d;
      head_q     <= head_d;
      count_q    <= count_d;
      instrd_q   <= instrd_d;
      pcp1d_q    <= pcp1d_d;
      validd_q   <= validd_d;
    end
  end

  assign imem.IMemReq  = issue;
  assign imem.IMemAddr = pcf_q;
  assign InstrD        = instrd_q;
  assign PCPlus1D      = pcp1d_q;
  assign ValidD        = validd_q;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (PCSrcE && (rcnt_q != 16'hFFFF)) begin
      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q <= 16'h0000;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign RedirectCnt = rcnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic against a queue-based reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [15:0] BranchTargetE;
  logic [15:0] InstrD, PCPlus1D;
  logic        ValidD;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] RedirectCnt;
`endif

  fetch_stage_if imem_if ();

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .PCSrcE        (PCSrcE),
    .BranchTargetE (BranchTargetE),
    .imem          (imem_if),
    .InstrD        (InstrD),
    .PCPlus1D      (PCPlus1D),
    .ValidD        (ValidD)
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    .RedirectCnt   (RedirectCnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetch queue of {instr, pc+1}, request bookkeeping, expected decode register.
  logic [31:0] m_q[$];
  bit          m_out, m_drop, m_vd, m_pd_chk;
  logic [15:0] m_pc, m_reqpc, m_id, m_pd, m_rc;

  // Memory responder.
  bit          r_pend, r_stray_once, r_stray_en;
  int          r_cnt, r_lat_min, r_lat_max;
  logic [15:0] r_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out    = 1'b0;
    m_drop   = 1'b0;
    m_vd     = 1'b0;
    m_pd_chk = 1'b1;
    m_pc     = 16'h0000;
    m_reqpc  = 16'h0000;
    m_id     = 16'h0000;
    m_pd     = 16'h0000;
    m_rc     = 16'h0000;
  endtask

  task automatic check_d();
    check16("ValidD", {15'b0, ValidD}, {15'b0, m_vd});
    check16("InstrD", InstrD, m_id);
    if (m_pd_chk) check16("PCPlus1D", PCPlus1D, m_pd);
`ifdef FETCH_REDIRECT_CNT_EN
    check16("RedirectCnt", RedirectCnt, m_rc);
`endif
  endtask

  task automatic check_zero(input string phase);
    check16({phase, "_IMemReq"}, {15'b0, imem_if.IMemReq}, 16'h0000);
    check16({phase, "_IMemAddr"}, imem_if.IMemAddr, 16'h0000);
    check16({phase, "_InstrD"}, InstrD, 16'h0000);
    check16({phase, "_PCPlus1D"}, PCPlus1D, 16'h0000);
    check16({phase, "_ValidD"}, {15'b0, ValidD}, 16'h0000);
`ifdef FETCH_REDIRECT_CNT_EN
    check16({phase, "_RedirectCnt"}, RedirectCnt, 16'h0000);
`endif
  endtask

  // One clock cycle: drive inputs, check request outputs, take the edge, advance model, check decode outputs.
  task automatic step(input bit sf, input bit sd, input bit fd, input bit pcs, input logic [15:0] tgt);
    bit          v, exp_req, dut_req, resp;
    logic [15:0] rd, dut_addr;
    logic [31:0] e;
    StallF        = sf;
    StallD        = sd;
    FlushD        = fd;
    PCSrcE        = pcs;
    BranchTargetE = tgt;
    v  = 1'b0;
    rd = 16'($urandom);
    if (r_stray_once) begin
      v            = 1'b1;
      r_stray_once = 1'b0;
    end else if (r_pend) begin
      r_cnt--;
      if (r_cnt == 0) begin
        v      = 1'b1;
        rd     = mem_word(r_addr);
        r_pend = 1'b0;
      end
    end else if (r_stray_en && ($urandom_range(0, 9) == 0)) begin
      v = 1'b1;
    end
    imem_if.IMemValid = v;
    imem_if.IMemRdata = rd;
    #1;
    exp_req = !sf && !pcs && !m_out && ((m_q.size() + int'(m_out)) < 2);
    check16("IMemReq", {15'b0, imem_if.IMemReq}, {15'b0, exp_req});
    if (exp_req) check16("IMemAddr", imem_if.IMemAddr, m_pc);
    dut_req  = imem_if.IMemReq;
    dut_addr = imem_if.IMemAddr;
    @(posedge clk);
    resp = v && m_out;
    if (fd) begin
      m_vd     = 1'b0;
      m_id     = 16'h0000;
      m_pd     = 16'h0000;
      m_pd_chk = 1'b1;
    end else if (!sd) begin
      if (m_q.size() > 0) begin
        e        = m_q.pop_front();
        m_vd     = 1'b1;
        m_id     = e[31:16];
        m_pd     = e[15:0];
        m_pd_chk = 1'b1;
      end else begin
        m_vd     = 1'b0;
        m_id     = 16'h0000;
        m_pd_chk = 1'b0;
      end
    end
    if (pcs) m_q.delete();
    if (resp && !m_drop && !pcs) m_q.push_back({rd, m_reqpc + 16'd1});
    if (pcs && m_out && !v) m_drop = 1'b1;
    else if (resp) m_drop = 1'b0;
    if (resp) m_out = 1'b0;
    if (pcs) begin
      m_pc = tgt;
      if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
    end else if (exp_req) begin
      m_out   = 1'b1;
      m_reqpc = m_pc;
      m_pc    = m_pc + 16'd1;
    end
    if (dut_req) begin
      r_pend = 1'b1;
      r_addr = dut_addr;
      r_cnt  = $urandom_range(r_lat_min, r_lat_max);
    end
    #1;
    check_d();
  endtask

  task automatic apply_reset(input bit stray);
    StallF        = 1'b0;
    StallD        = 1'b0;
    FlushD        = 1'b0;
    PCSrcE        = 1'b0;
    BranchTargetE = 16'h0000;
    imem_if.IMemValid = 1'b0;
    reset = 1'b0;
    #1;
    check_zero("rst_now");
    model_reset();
    r_pend       = 1'b0;
    r_stray_once = stray;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset = 1'b1;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    reset             = 1'b0;
    StallF            = 1'b0;
    StallD            = 1'b0;
    FlushD            = 1'b0;
    PCSrcE            = 1'b0;
    BranchTargetE     = 16'h0000;
    imem_if.IMemValid = 1'b0;
    imem_if.IMemRdata = 16'h0000;
    r_pend            = 1'b0;
    r_stray_once      = 1'b0;
    r_stray_en        = 1'b0;
    r_cnt             = 0;
    r_addr            = 16'h0000;
    r_lat_min         = 1;
    r_lat_max         = 1;
    model_reset();
    #1;
    apply_reset(1'b0);

    // Latency-1 stream from address 0.
    run_idle(16);

    // Hold decode so the queue fills, then release.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    run_idle(8);

    // Redirect to 0x0040 while a latency-3 request is in flight.
    r_lat_min = 3;
    r_lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      if (m_out && r_pend && (r_cnt > 1)) break;
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
    run_idle(14);

    // Flush and stall together with a non-empty queue.
    r_lat_min = 1;
    r_lat_max = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    run_idle(6);

    // Address wrap at 0xFFFF.
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    run_idle(12);

    // Reset while a request is outstanding, stray response right after release.
    r_lat_min = 3;
    r_lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      if (m_out) break;
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    apply_reset(1'b1);
    run_idle(10);

    // Randomized traffic.
    r_lat_min  = 1;
    r_lat_max  = 4;
    r_stray_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit          sf, sd, fd, pcs;
      logic [15:0] tgt;
      if (i == 300) apply_reset(1'b1);
      sf  = ($urandom_range(0, 4) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      pcs = ($urandom_range(0, 11) == 0);
      fd  = pcs || ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (16'hFFFD + 16'($urandom_range(0, 2))) : 16'($urandom);
      step(sf, sd, fd, pcs, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
